key_debounce: RTL and testbench
===============================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001: Parameter STABLE_CYCLES, default 50000, is the number of consecutive cycles the synchronized key must be stable before a level change is accepted (minimum 1).
REQ-002: Parameter CNT_W, default 16, is the stability counter width; 2^CNT_W >= STABLE_CYCLES SHALL hold.
REQ-003: clk  input  1  system clock; all state changes on its rising edge.
REQ-004: reset  input  1  synchronous, active-high reset.
REQ-005: key_n  input  1  raw asynchronous pushbutton, active-low (0 = pressed).
REQ-006: out  output  1  debounced key level, active-high (1 = pressed); drives the downstream release-detect stage.
REQ-007: press_pulse  output  1  one-cycle pulse when a press is accepted.
REQ-008: release_pulse  output  1  one-cycle pulse when a release is accepted.

Function
REQ-009: key_n SHALL pass through a two-flop synchronizer; sync = inverted second-stage output (1 = pressed).
REQ-010: The FSM SHALL have exactly four states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011: RELEASED: sync=1 -> PRESS_WAIT with cnt cleared to 0; otherwise hold.
REQ-012: PRESS_WAIT: sync=0 -> RELEASED, no pulse; else cnt==STABLE_CYCLES-1 -> PRESSED; else cnt increments by 1.
REQ-013: PRESSED: sync=0 -> RELEASE_WAIT with cnt cleared to 0; otherwise hold.
REQ-014: RELEASE_WAIT: sync=1 -> PRESSED, no pulse; else cnt==STABLE_CYCLES-1 -> RELEASED; else cnt increments by 1.
REQ-015: out, press_pulse and release_pulse SHALL be registered, updated on the same edge as the state register.
REQ-016: out SHALL be 1 whenever the registered state is PRESSED or RELEASE_WAIT, 0 otherwise.
REQ-017: press_pulse SHALL be 1 for exactly the one cycle following the PRESS_WAIT->PRESSED edge; release_pulse likewise for RELEASE_WAIT->RELEASED.
REQ-018: press_pulse and release_pulse SHALL never be 1 in the same cycle.
REQ-019: Latency: numbering the first edge that samples key_n=0 as edge 1, with key_n held low, out and press_pulse SHALL assert after edge STABLE_CYCLES+3; release is symmetric.
REQ-020: A bounce (sync returning to the old level) in either WAIT state SHALL abandon the change with no output pulse and no change in out.
REQ-021: cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-022: STABLE_CYCLES=1 SHALL accept a change on the edge after the WAIT state is entered.
REQ-023: A release of fewer than STABLE_CYCLES synchronized cycles while PRESSED SHALL leave out=1 and release_pulse=0.

Reset
REQ-024: reset=1 at a rising edge SHALL set state=RELEASED, cnt=0, both synchronizer flops to the released level (key_n=1), out=0, press_pulse=0, release_pulse=0.
REQ-025: Reset SHALL take priority over every transition, including mid-WAIT and on the accepting edge itself; no pulse SHALL be emitted for an edge at which reset=1.
REQ-026: A key held pressed through reset SHALL be detected afresh after reset deasserts, with full REQ-019 latency counted from the first non-reset edge.

Verification (STABLE_CYCLES=4, CNT_W=3)
REQ-027: Reset 2 cycles, key_n=1 -> out=0, both pulses 0 for 20 cycles.
REQ-028: key_n 1->0 held 12 cycles -> out=1 and press_pulse=1 after edge 7, press_pulse=0 after edge 8, out stays 1.
REQ-029: From PRESSED, key_n=1 held -> out=0 and release_pulse=1 after edge 7, single-cycle pulse.
REQ-030: key_n toggling 0/1 every 2 cycles for 20 cycles -> out=0, no pulses; then held 0 -> press accepted with full latency.
REQ-031: From PRESSED, key_n=1 for 3 cycles then 0 -> out stays 1, release_pulse never asserted.
REQ-032: key_n=0, reset asserted while in PRESS_WAIT (cnt=2) for one cycle -> out=0, no pulse; press accepted after edge 7 counted from first post-reset edge.

Source files
------------

// File: rtl/key_debounce.sv
// Pushbutton debouncer: two-flop synchronizer followed by a four-state stability FSM.
// Emits a registered debounced level plus one-cycle press/release pulses.
module key_debounce #(
    parameter int unsigned STABLE_CYCLES = 50000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic out,
    output logic press_pulse,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       key_sync;
    state_e     state_q;
    state_e     state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic       out_q;
    logic       out_d;
    logic       press_q;
    logic       press_d;
    logic       release_q;
    logic       release_d;

    // Synchronizer resets to the released level so a held key is seen afresh.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    assign key_sync = ~sync2_q;

    // State, counter and output registers all update on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            out_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (key_sync) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!key_sync) begin
                    state_d = RELEASED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!key_sync) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (key_sync) begin
                    state_d = PRESSED;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RELEASED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs derived from the upcoming state so they register alongside it.
    always_comb begin
        out_d     = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = (state_q == PRESS_WAIT) && (state_d == PRESSED);
        release_d = (state_q == RELEASE_WAIT) && (state_d == RELEASED);
    end

    assign out           = out_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed latency/bounce/reset scenarios
// plus randomized key activity compared every cycle against a run-length model.
module tb_key_debounce;

    localparam int unsigned S     = 4;
    localparam int unsigned CNT_W = 3;

    logic clk;
    logic reset;
    logic key_n;
    logic out;
    logic press_pulse;
    logic release_pulse;

    int checks;
    int errors;

    key_debounce #(
        .STABLE_CYCLES(S),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .key_n        (key_n),
        .out          (out),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the FSM sees key_n delayed by two edges; a change is accepted once the
    // synchronized level has differed from the accepted level on S+1 consecutive edges.
    logic [1:0] m_hist;
    logic       m_out;
    logic       m_press;
    logic       m_release;
    int         m_run;
    logic       m_valid;

    initial begin
        m_valid   = 1'b0;
        m_hist    = 2'b11;
        m_out     = 1'b0;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_run     = 0;
    end

    always @(posedge clk) begin
        logic s;
        if (reset) begin
            m_hist    = 2'b11;
            m_out     = 1'b0;
            m_press   = 1'b0;
            m_release = 1'b0;
            m_run     = 0;
            m_valid   = 1'b1;
        end else begin
            s         = ~m_hist[1];
            m_hist    = {m_hist[0], key_n};
            m_press   = 1'b0;
            m_release = 1'b0;
            if (s != m_out) begin
                m_run = m_run + 1;
                if (m_run == int'(S) + 1) begin
                    m_out     = s;
                    m_press   = s;
                    m_release = ~s;
                    m_run     = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_out", out, m_out);
            check("model_press", press_pulse, m_press);
            check("model_release", release_pulse, m_release);
            check("pulse_exclusive", press_pulse & release_pulse, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        key_n  = 1'b1;

        // Idle after reset: nothing moves.
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_out", out, 1'b0);
            check("idle_pulses", press_pulse | release_pulse, 1'b0);
        end

        // Press latency: accepted after edge S+3.
        key_n = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("press_out", out, (e >= 7));
            check("press_pulse", press_pulse, (e == 7));
        end

        // Release latency, symmetric.
        key_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("release_out", out, (e < 7));
            check("release_pulse", release_pulse, (e == 7));
        end

        // Bouncing every 2 cycles is never accepted.
        for (int i = 0; i < 20; i++) begin
            key_n = logic'((i >> 1) & 1);
            tick();
            check("bounce_out", out, 1'b0);
            check("bounce_pulses", press_pulse | release_pulse, 1'b0);
        end
        key_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("after_bounce_out", out, (e >= 7));
            check("after_bounce_press", press_pulse, (e == 7));
        end

        // Short release while pressed is ignored.
        key_n = 1'b1;
        for (int e = 1; e <= 3; e++) tick();
        key_n = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("short_release_out", out, 1'b1);
            check("short_release_pulse", release_pulse, 1'b0);
        end

        // Release, then reset mid PRESS_WAIT (cnt=2) with the key held.
        key_n = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        key_n = 1'b0;
        for (int e = 1; e <= 5; e++) tick();
        reset = 1'b1;
        tick();
        check("midwait_reset_out", out, 1'b0);
        check("midwait_reset_pulse", press_pulse, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("post_reset_out", out, (e >= 7));
            check("post_reset_press", press_pulse, (e == 7));
        end

        // Reset on the accepting edge suppresses the pulse.
        key_n = 1'b1;
        for (int e = 1; e <= 10; e++) tick();
        key_n = 1'b0;
        for (int e = 1; e <= 6; e++) tick();
        reset = 1'b1;
        tick();
        check("accept_edge_reset_out", out, 1'b0);
        check("accept_edge_reset_pulse", press_pulse, 1'b0);
        reset = 1'b0;
        key_n = 1'b1;

        // Randomized key activity with occasional resets.
        for (int seg = 0; seg < 300; seg++) begin
            int len;
            key_n = logic'($urandom_range(0, 1));
            len   = int'($urandom_range(1, 12));
            for (int c = 0; c < len; c++) begin
                reset = ($urandom_range(0, 39) == 0);
                tick();
            end
            reset = 1'b0;
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
